// File: rtl/pattern_derotator_pkg.sv
// Shared types and helpers for the nibble rotator / derotator pair.
// The rotation function here is the transmit-side reference used by bench models.
package pattern_pkg;

    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NUM_NIB = 4;
    localparam int unsigned WORD_W  = NIB_W * NUM_NIB;

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;

    typedef logic [WORD_W-1:0] word_t;

    // Nibble i of d lands at position (i + s) mod NUM_NIB.
    function automatic word_t rotl_nib(word_t d, logic [1:0] s);
        int unsigned k;
        k = 32'(s) * NIB_W;
        return (d << k) | (d >> (WORD_W - k));
    endfunction

endpackage

// File: rtl/pattern_derotator_if.sv
// Valid/ready stream bundle: rotated word in, de-rotated result out.
interface pattern_derotator_if;
    import pattern_pkg::*;

    logic       in_valid;
    logic       in_ready;
    word_t      in_data;
    logic       out_valid;
    logic       out_ready;
    word_t      out_data;
    logic [1:0] out_shift;
    logic       out_match;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_shift, out_match
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_shift, out_match
    );

endinterface

// File: rtl/pattern_derotator_nibble_rotr.sv
// Combinational right rotation of a word by 0-3 nibbles; undoes rotl_nib.
module nibble_rotr
    import pattern_pkg::*;
(
    input  word_t      word,
    input  logic [1:0] shift,
    output word_t      result
);

    always_comb begin
        result = word;
        case (shift)
            2'd0: result = word;
            2'd1: result = {word[NIB_W-1:0],   word[WORD_W-1:NIB_W]};
            2'd2: result = {word[2*NIB_W-1:0], word[WORD_W-1:2*NIB_W]};
            2'd3: result = {word[3*NIB_W-1:0], word[WORD_W-1:3*NIB_W]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/pattern_derotator.sv
// Recovers the nibble rotation applied to a word by trying shifts 0..3 in turn
// against a reference pattern; keeps saturating match/miss statistics.
module pattern_derotator
    import pattern_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter word_t       RESET_REF = 16'h4321
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ref_load,
    input  word_t                ref_data,
    pattern_derotator_if.slave   bus,
    output logic [CNT_W-1:0]     match_cnt,
    output logic [CNT_W-1:0]     miss_cnt
);

    state_e           state_q, state_d;
    word_t            word_q, word_d;
    word_t            ref_q, ref_d;
    logic [1:0]       cand_q, cand_d;
    logic             out_valid_q, out_valid_d;
    word_t            out_data_q, out_data_d;
    logic [1:0]       out_shift_q, out_shift_d;
    logic             out_match_q, out_match_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    word_t            rot_word;

    nibble_rotr u_rotr (
        .word   (word_q),
        .shift  (cand_q),
        .result (rot_word)
    );

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        ref_d       = ref_q;
        cand_d      = cand_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_shift_d = out_shift_q;
        out_match_d = out_match_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        if (ref_load) begin
            ref_d = ref_data;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    word_d  = bus.in_data;
                    cand_d  = '0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                // A reference change invalidates candidates already rejected.
                if (ref_load) begin
                    cand_d = '0;
                end else if (rot_word == ref_q) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = rot_word;
                    out_shift_d = cand_q;
                    out_match_d = 1'b1;
                    if (match_cnt_q != {CNT_W{1'b1}}) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                    end
                end else if (cand_q == 2'd3) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = word_q;
                    out_shift_d = '0;
                    out_match_d = 1'b0;
                    if (miss_cnt_q != {CNT_W{1'b1}}) begin
                        miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end else begin
                    cand_d = cand_q + 2'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            ref_q       <= RESET_REF;
            cand_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_shift_q <= '0;
            out_match_q <= 1'b0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            ref_q       <= ref_d;
            cand_q      <= cand_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_shift_q <= out_shift_d;
            out_match_q <= out_match_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_shift = out_shift_q;
    assign bus.out_match = out_match_q;
    assign match_cnt     = match_cnt_q;
    assign miss_cnt      = miss_cnt_q;

endmodule
